htol_buffer: RTL and testbench

HTOL_BUFFER -- requirements
Module: htol_buffer

---
 rtl/htol_buffer.sv | 147 ++++++++++++++
 tb/tb_htol_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/htol_buffer.sv
// htol_buffer: single-clock word buffer with paced output.
// Words are written at up to one per cycle and emitted at most one per DIV
// cycles, in FIFO order, whenever the downstream ren permits it in a slot.
// Optional feature: define HTOL_OVF_FLAG_EN to add a sticky ovf output that
// flags any write dropped because the buffer was full.
module htol_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LOC        = 64,
    parameter int ADD_WIDTH  = 6,
    parameter int DIV        = 4
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid,
    output logic                  full,
    output logic                  empty,
    output logic [ADD_WIDTH:0]    count
`ifdef HTOL_OVF_FLAG_EN
    ,
    output logic                  ovf
`endif
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] SLOT = PW'(DIV - 1);
    localparam logic [ADD_WIDTH:0] FULL_CNT = (ADD_WIDTH + 1)'(LOC);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [LOC];
    logic [ADD_WIDTH:0]    wptr;
    logic [ADD_WIDTH:0]    rptr;
    logic [PW-1:0]         pctr;
    logic                  slot;
    logic                  wr;
    logic                  pop;

    // Flags come from the pre-edge count, so a pop cannot make room for a
    // write on the same edge, and a fresh write cannot be popped at once.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign slot  = (pctr == SLOT);

    // Next state and the write/pop strobes for this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_nxt = state;
        wr        = wen && !full;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                pop = slot && ren && !empty;
                if (pop && !wr && (count == (ADD_WIDTH + 1)'(1))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge wclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Free-running pacing counter; the emission slot is its last value.
    always_ff @(posedge wclk) begin
        if (rst || slot) begin
            pctr <= '0;
        end else begin
            pctr <= pctr + 1'b1;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge wclk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge wclk) begin
        // NOTE: the array has no reset; stale words are unreachable once the pointers clear.
        if (wr && !rst) begin
            mem[wptr[ADD_WIDTH-1:0]] <= din;
        end
    end

    // Registered output word and its one-cycle strobe; dout holds between pops.
    always_ff @(posedge wclk) begin
        if (rst) begin
            dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            dvalid <= pop;
            if (pop) begin
                dout <= mem[rptr[ADD_WIDTH-1:0]];
            end
        end
    end

`ifdef HTOL_OVF_FLAG_EN
    // Sticky overflow flag, set by any write dropped while full.
    always_ff @(posedge wclk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wen && full) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_htol_buffer.sv
// Directed testbench for htol_buffer with DIV=4, LOC=64, DATA_WIDTH=32.
// After each reset edge the pacing counter is 0, so the slot edges are the
// 4th, 8th, 12th ... edges after the reset edge.
module tb_htol_buffer;

    logic        wclk;
    logic        rst;
    logic        wen;
    logic [31:0] din;
    logic        ren;
    logic [31:0] dout;
    logic        dvalid;
    logic        full;
    logic        empty;
    logic [6:0]  count;
`ifdef HTOL_OVF_FLAG_EN
    logic        ovf;
`endif

    int checks;
    int errors;
    int since_rst;

    htol_buffer #(
        .DATA_WIDTH(32),
        .LOC       (64),
        .ADD_WIDTH (6),
        .DIV       (4)
    ) dut (
        .wclk  (wclk),
        .rst   (rst),
        .wen   (wen),
        .din   (din),
        .ren   (ren),
        .dout  (dout),
        .dvalid(dvalid),
        .full  (full),
        .empty (empty),
        .count (count)
`ifdef HTOL_OVF_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge wclk);
        #1;
        since_rst = since_rst + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        din = '0;
        tick();
        rst = 1'b0;
        since_rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b expected 0", dvalid); end
        if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
`ifdef HTOL_OVF_FLAG_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    endtask

    // 8 back-to-back writes 0x10..0x17 with ren high: one word per slot.
    task automatic test_stream();
        logic [31:0] last;
        logic        exp_dv;
        do_reset();
        last = 32'h0;
        for (int e = 1; e <= 36; e++) begin
            wen = (e <= 8);
            din = 32'(32'h10 + e - 1);
            ren = 1'b1;
            tick();
            exp_dv = (e % 4 == 0) && (e >= 4) && (e <= 32);
            if (exp_dv) last = 32'(32'h10 + e / 4 - 1);
            checks += 2;
            if (dvalid !== exp_dv) begin errors++; $display("FAIL stream_dvalid e=%0d: got %b expected %b", e, dvalid, exp_dv); end
            if (dout !== last) begin errors++; $display("FAIL stream_dout e=%0d: got %h expected %h", e, dout, last); end
            if (e == 8) begin
                checks++;
                if (count !== 7'd6) begin errors++; $display("FAIL stream_count8: got %0d expected 6", count); end
            end
        end
        wen = 1'b0;
        checks += 2;
        if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b expected 1", empty); end
        if (count !== 7'd0) begin errors++; $display("FAIL stream_count_end: got %0d expected 0", count); end
    endtask

    // Fill past capacity, then a write colliding with a pop while full, then drain.
    task automatic test_fill();
        logic        exp_dv;
        logic [31:0] exp_d;
        do_reset();
        ren = 1'b0;
        for (int e = 1; e <= 68; e++) begin
            wen = 1'b1;
            din = 32'(e - 1);
            tick();
            if (e == 63) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("FAIL fill_full63: got %b expected 0", full); end
            end
            if (e == 64) begin
                checks += 2;
                if (full !== 1'b1) begin errors++; $display("FAIL fill_full64: got %b expected 1", full); end
                if (count !== 7'd64) begin errors++; $display("FAIL fill_count64: got %0d expected 64", count); end
            end
        end
        checks += 3;
        if (count !== 7'd64) begin errors++; $display("FAIL fill_count68: got %0d expected 64", count); end
        if (full !== 1'b1) begin errors++; $display("FAIL fill_full68: got %b expected 1", full); end
        if (dvalid !== 1'b0) begin errors++; $display("FAIL fill_dvalid68: got %b expected 0", dvalid); end
`ifdef HTOL_OVF_FLAG_EN
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b expected 1", ovf); end
`endif
        // Edges 69..71 are not slots; edge 72 is a slot with write and pop together.
        wen = 1'b0;
        ren = 1'b1;
        repeat (3) tick();
        wen = 1'b1;
        din = 32'hAA;
        tick();
        wen = 1'b0;
        checks += 4;
        if (dvalid !== 1'b1) begin errors++; $display("FAIL fullpop_dvalid: got %b expected 1", dvalid); end
        if (dout !== 32'h0) begin errors++; $display("FAIL fullpop_dout: got %h expected 0", dout); end
        if (count !== 7'd63) begin errors++; $display("FAIL fullpop_count: got %0d expected 63", count); end
        if (full !== 1'b0) begin errors++; $display("FAIL fullpop_full: got %b expected 0", full); end
        // Remaining words 1..63 come out at edges 76..324; nothing else follows.
        for (int e = 73; e <= 332; e++) begin
            tick();
            exp_dv = (e % 4 == 0) && (e <= 324);
            exp_d  = 32'((e - 72) / 4);
            checks++;
            if (dvalid !== exp_dv) begin errors++; $display("FAIL drain_dvalid e=%0d: got %b expected %b", e, dvalid, exp_dv); end
            if (exp_dv) begin
                checks++;
                if (dout !== exp_d) begin errors++; $display("FAIL drain_dout e=%0d: got %h expected %h", e, dout, exp_d); end
            end
        end
        checks += 2;
        if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
        if (dout !== 32'd63) begin errors++; $display("FAIL drain_hold: got %h expected 3f", dout); end
`ifdef HTOL_OVF_FLAG_EN
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL drain_ovf_held: got %b expected 1", ovf); end
`endif
    endtask

    // A write landing on a slot edge into an empty buffer waits for the next slot.
    task automatic test_slot_write();
        logic exp_dv;
        do_reset();
        ren = 1'b1;
        repeat (3) tick();
        wen = 1'b1;
        din = 32'h55;
        tick();
        wen = 1'b0;
        checks += 3;
        if (dvalid !== 1'b0) begin errors++; $display("FAIL slotwr_dvalid4: got %b expected 0", dvalid); end
        if (count !== 7'd1) begin errors++; $display("FAIL slotwr_count: got %0d expected 1", count); end
        if (empty !== 1'b0) begin errors++; $display("FAIL slotwr_empty: got %b expected 0", empty); end
        for (int e = 5; e <= 8; e++) begin
            tick();
            exp_dv = (e == 8);
            checks++;
            if (dvalid !== exp_dv) begin errors++; $display("FAIL slotwr_dvalid e=%0d: got %b expected %b", e, dvalid, exp_dv); end
        end
        checks += 2;
        if (dout !== 32'h55) begin errors++; $display("FAIL slotwr_dout: got %h expected 55", dout); end
        if (count !== 7'd0) begin errors++; $display("FAIL slotwr_count_end: got %0d expected 0", count); end
    endtask

    // ren low through slots 4, 8, 12; emission resumes at slot 16 in order.
    task automatic test_ren_gate();
        logic        exp_dv;
        logic [31:0] exp_d;
        do_reset();
        for (int e = 1; e <= 28; e++) begin
            wen = (e <= 3);
            din = 32'(32'hA0 + e - 1);
            ren = (e > 12);
            tick();
            exp_dv = (e == 16) || (e == 20) || (e == 24);
            exp_d  = 32'(32'hA0 + (e - 16) / 4);
            checks++;
            if (dvalid !== exp_dv) begin errors++; $display("FAIL rengate_dvalid e=%0d: got %b expected %b", e, dvalid, exp_dv); end
            if (exp_dv) begin
                checks++;
                if (dout !== exp_d) begin errors++; $display("FAIL rengate_dout e=%0d: got %h expected %h", e, dout, exp_d); end
            end
        end
        wen = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL rengate_empty: got %b expected 1", empty); end
    endtask

    // 130 writes interleaved with drains (pointers wrap), then reset mid-drain.
    task automatic test_wrap_reset();
        logic [31:0] q[$];
        logic [31:0] exp_d;
        logic        exp_dv;
        int          nwr;
        int          pre;
        int          e;
        do_reset();
        q     = {};
        nwr   = 0;
        e     = 0;
        exp_d = '0;
        ren   = 1'b1;
        while (nwr < 130 || !((e % 4 == 3) && (e >= 423))) begin
            e++;
            wen = (nwr < 130) && ((e % 4 == 1) || ((e < 100) && (e % 4 == 2)));
            din = 32'(32'hC000 + nwr);
            pre = q.size();
            tick();
            exp_dv = (e % 4 == 0) && (pre > 0);
            if (exp_dv) exp_d = q.pop_front();
            if (wen) begin
                q.push_back(din);
                nwr++;
            end
            checks += 2;
            if (dvalid !== exp_dv) begin errors++; $display("FAIL wrap_dvalid e=%0d: got %b expected %b", e, dvalid, exp_dv); end
            if (count !== 7'(q.size())) begin errors++; $display("FAIL wrap_count e=%0d: got %0d expected %0d", e, count, q.size()); end
            if (exp_dv) begin
                checks++;
                if (dout !== exp_d) begin errors++; $display("FAIL wrap_dout e=%0d: got %h expected %h", e, dout, exp_d); end
            end
        end
        // Reset lands on what would be a slot edge, with a write also requested.
        rst = 1'b1;
        wen = 1'b1;
        din = 32'hDEAD;
        ren = 1'b1;
        tick();
        rst = 1'b0;
        wen = 1'b0;
        since_rst = 0;
        checks += 4;
        if (count !== 7'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
        if (dvalid !== 1'b0) begin errors++; $display("FAIL midrst_dvalid: got %b expected 0", dvalid); end
        if (dout !== 32'h0) begin errors++; $display("FAIL midrst_dout: got %h expected 0", dout); end
        if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", empty); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (dvalid !== 1'b0) begin errors++; $display("FAIL postrst_dvalid k=%0d: got %b expected 0", k, dvalid); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        since_rst = 0;
        rst       = 1'b1;
        wen       = 1'b0;
        ren       = 1'b0;
        din       = '0;
        test_reset();
        test_stream();
        test_fill();
        test_slot_write();
        test_ren_gate();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
